// File: rtl/seg_scan_ctrl_if.sv
// Display-image write port and LED-side outputs of seg_scan_ctrl.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  wr_en;
    logic [4*DIGITS-1:0]   wr_data;
    logic [DIGITS-1:0]     wr_dp;
    logic [DIGITS-1:0]     wr_mask;
    logic [3:0]            data_disp;
    logic                  dp;
    logic [DIGITS-1:0]     digit_sel;
    logic                  frame_done;
    logic                  pending;

    modport master (
        output en, wr_en, wr_data, wr_dp, wr_mask,
        input  data_disp, dp, digit_sel, frame_done, pending
    );

    modport slave (
        input  en, wr_en, wr_data, wr_dp, wr_mask,
        output data_disp, dp, digit_sel, frame_done, pending
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller with double-buffered image.
// Optional leading-zero blanking via macro SEG_SCAN_LZ_BLANK_EN.
//   state   | meaning
//   S_OFF   | scan stopped, all digits off, idx/counter held at 0
//   S_BLANK | first BLANK_CYC cycles of a slot, digits off, nibble presented
//   S_ON    | rest of slot, digit idx driven unless masked
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_ctrl_if.slave    bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_ON} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pd_data_q, pd_data_d, sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   pd_dp_q, pd_dp_d, sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   pd_mask_q, pd_mask_d, sh_mask_q, sh_mask_d;
    logic                pd_valid_q, pd_valid_d;
    logic [3:0]          data_disp_q, data_disp_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                frame_done_q, frame_done_d;
    logic                boundary;
    logic                lz_run;
    logic [DIGITS-1:0]   lz_mask, eff_mask;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        boundary     = 1'b0;
        frame_done_d = 1'b0;
        if (!bus.en) begin
            state_d = S_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d  = S_BLANK;
                    cnt_d    = '0;
                    idx_d    = '0;
                    boundary = 1'b1;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = S_ON;
                end
                S_ON: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            boundary     = 1'b1;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // A write landing on a boundary bypasses the pending buffer.
    always_comb begin
        pd_data_d  = pd_data_q;
        pd_dp_d    = pd_dp_q;
        pd_mask_d  = pd_mask_q;
        pd_valid_d = pd_valid_q;
        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        sh_mask_d  = sh_mask_q;
        if (boundary) begin
            if (bus.wr_en) begin
                sh_data_d = bus.wr_data;
                sh_dp_d   = bus.wr_dp;
                sh_mask_d = bus.wr_mask;
            end else if (pd_valid_q) begin
                sh_data_d = pd_data_q;
                sh_dp_d   = pd_dp_q;
                sh_mask_d = pd_mask_q;
            end
            pd_valid_d = 1'b0;
        end else if (bus.wr_en) begin
            pd_data_d  = bus.wr_data;
            pd_dp_d    = bus.wr_dp;
            pd_mask_d  = bus.wr_mask;
            pd_valid_d = 1'b1;
        end
    end

    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (sh_data_d[4*i +: 4] == 4'h0) && !sh_dp_d[i])
                lz_mask[i] = 1'b1;
            else
                lz_run = 1'b0;
        end
`endif
        eff_mask = sh_mask_d | lz_mask;
    end

    // Outputs are computed from next-state values so they line up with state_q.
    always_comb begin
        data_disp_d = 4'h0;
        dp_d        = 1'b0;
        sel_d       = '1;
        if (state_d != S_OFF) begin
            data_disp_d = sh_data_d[{idx_d, 2'b00} +: 4];
            dp_d        = sh_dp_d[idx_d];
            if (state_d == S_ON && !eff_mask[idx_d]) sel_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            idx_q        <= '0;
            pd_data_q    <= '0;
            pd_dp_q      <= '0;
            pd_mask_q    <= '0;
            pd_valid_q   <= 1'b0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_mask_q    <= '1;
            data_disp_q  <= 4'h0;
            dp_q         <= 1'b0;
            sel_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pd_data_q    <= pd_data_d;
            pd_dp_q      <= pd_dp_d;
            pd_mask_q    <= pd_mask_d;
            pd_valid_q   <= pd_valid_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_mask_q    <= sh_mask_d;
            data_disp_q  <= data_disp_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.data_disp  = data_disp_q;
    assign bus.dp         = dp_q;
    assign bus.digit_sel  = sel_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pd_valid_q;
endmodule
